// File: rtl/cas_sort_seq_if.sv
// Stream bundle for cas_sort_seq: serial word input, serial sorted-word output, busy flag.
// The slave modport is the sorter; the master modport is the surrounding producer/consumer.
interface cas_sort_seq_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/cas_sort_seq.sv
// Time-multiplexed odd-even transposition sorter: loads NUM words, sorts them descending
// with one shared compare-and-swap per cycle, then drains them through a valid/ready port.
module cas_sort_seq #(
    parameter int WIDTH = 6,
    parameter int NUM   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    cas_sort_seq_if.slave  bus
);
    localparam int PTR_W      = $clog2(NUM);
    localparam int PASS_W     = PTR_W + 1;
    localparam int ODD_LAST_I = (NUM > 2) ? (NUM - 3) : 0;
    localparam bit SINGLE_PASS = (NUM == 2);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_TWO   = PTR_W'(2);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM - 1);
    localparam logic [PTR_W-1:0]  EVEN_LAST = PTR_W'(NUM - 2);
    localparam logic [PTR_W-1:0]  ODD_LAST  = PTR_W'(ODD_LAST_I);
    localparam logic [PASS_W-1:0] PASS_ZERO = PASS_W'(0);
    localparam logic [PASS_W-1:0] PASS_ONE  = PASS_W'(1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM - 1);

    // Borrow of the WIDTH+1-bit difference a-b: set exactly when a < b.
    function automatic logic borrow_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[WIDTH];
    endfunction

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WIDTH-1:0]  r_mem [NUM];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_pair;
    logic [PASS_W-1:0] r_pass;

    logic [PTR_W-1:0]  w_idx_b;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic              w_swap;
    logic [PTR_W-1:0]  w_pair_end;
    logic              w_last_pair;
    logic              w_last_pass;
    logic              w_sort_done;
    logic              w_accept;
    logic              w_last_in;
    logic              w_xfer;
    logic              w_last_out;

    assign w_idx_b     = r_pair + PTR_ONE;
    assign w_a         = r_mem[r_pair];
    assign w_b         = r_mem[w_idx_b];
    assign w_swap      = borrow_of(w_a, w_b);
    assign w_pair_end  = r_pass[0] ? ODD_LAST : EVEN_LAST;
    assign w_last_pair = (r_pair == w_pair_end);
    // With two words the odd passes have no pairs, so the first pass is also the last.
    assign w_last_pass = (r_pass == PASS_LAST) || SINGLE_PASS;
    assign w_sort_done = w_last_pair && w_last_pass;
    assign w_accept    = bus.in_valid && (r_state == ST_LOAD);
    assign w_last_in   = w_accept && (r_wr_ptr == PTR_LAST);
    assign w_xfer      = bus.out_ready && (r_state == ST_DRAIN);
    assign w_last_out  = w_xfer && (r_rd_ptr == PTR_LAST);

    // Handshake outputs decode from registered state only.
    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.out_valid = (r_state == ST_DRAIN);
    assign bus.busy      = (r_state == ST_SORT) || (r_state == ST_DRAIN);
    assign bus.out_data  = (r_state == ST_DRAIN) ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};

    // Next-state selection for the LOAD -> SORT -> DRAIN cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  w_state_nxt = w_last_in   ? ST_SORT  : ST_LOAD;
            ST_SORT:  w_state_nxt = w_sort_done ? ST_DRAIN : ST_SORT;
            ST_DRAIN: w_state_nxt = w_last_out  ? ST_LOAD  : ST_DRAIN;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    // State register plus load/drain pointers and the pass/pair schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_LOAD;
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_pair   <= PTR_ZERO;
            r_pass   <= PASS_ZERO;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_wr_ptr <= w_last_in ? PTR_ZERO : (r_wr_ptr + PTR_ONE);
                    end
                end
                ST_SORT: begin
                    if (!w_last_pair) begin
                        r_pair <= r_pair + PTR_TWO;
                    end else if (w_last_pass) begin
                        r_pass <= PASS_ZERO;
                        r_pair <= PTR_ZERO;
                    end else begin
                        // Next pass has opposite parity: odd passes start at pair 1.
                        r_pass <= r_pass + PASS_ONE;
                        r_pair <= r_pass[0] ? PTR_ZERO : PTR_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer) begin
                        r_rd_ptr <= w_last_out ? PTR_ZERO : (r_rd_ptr + PTR_ONE);
                    end
                end
                default: begin
                    r_wr_ptr <= PTR_ZERO;
                    r_rd_ptr <= PTR_ZERO;
                    r_pair   <= PTR_ZERO;
                    r_pass   <= PASS_ZERO;
                end
            endcase
        end
    end

    // Register file: serial writes in LOAD, in-place compare-and-swap in SORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM; k++) begin
                r_mem[k] <= {WIDTH{1'b0}};
            end
        end else if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end else if ((r_state == ST_SORT) && w_swap) begin
            r_mem[r_pair]  <= w_b;
            r_mem[w_idx_b] <= w_a;
        end
    end
endmodule

// File: tb/tb_cas_sort_seq.sv
// Self-checking bench for cas_sort_seq: directed vector table, reset abort, backpressure,
// and randomized vectors checked against a selection-sort reference.
module tb_cas_sort_seq;
    localparam int W        = 6;
    localparam int N        = 4;
    localparam int SORT_CYC = N * (N - 1) / 2;

    typedef logic [W-1:0] word_t;
    typedef struct {
        word_t       din [N];
        word_t       exp [N];
        bit          gap;
        logic [15:0] rdy;
        bit          offer;
        bit          abort_first;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl [7];

    cas_sort_seq_if #(.WIDTH(W)) bus ();
    cas_sort_seq #(.WIDTH(W), .NUM(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: repeatedly pick the largest remaining word.
    task automatic ref_sort(input word_t din [N], output word_t dout [N]);
        bit used [N];
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int o = 0; o < N; o++) begin
            int best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i] && (best < 0 || din[i] > din[best])) best = i;
            end
            used[best] = 1'b1;
            dout[o] = din[best];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  int'(bus.in_ready),  1);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_out_data"},  int'(bus.out_data),  0);
        check({tag, "_busy"},      int'(bus.busy),      0);
    endtask

    task automatic send(input word_t din [N], input bit gap);
        int idx = 0;
        int cyc = 0;
        bit phase = 1'b0;
        while (idx < N && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gap && phase) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = din[idx];
            end
            phase = ~phase;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        check("load_accepts", idx, N);
    endtask

    task automatic wait_sort(output int sort_cnt);
        int bad = 0;
        int cyc = 0;
        bit done = 1'b0;
        sort_cnt = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                done = 1'b1;
            end else begin
                sort_cnt++;
                if (!bus.busy || bus.in_ready) bad++;
            end
        end
        check("sort_cycles", sort_cnt, SORT_CYC);
        check("sort_flags_bad", bad, 0);
    endtask

    task automatic drain(input logic [15:0] rdy, input bit offer, output word_t res [N],
                         output int dcyc, output int busy_hi);
        int got = 0;
        int flag_bad = 0;
        int early = 0;
        int unstable = 0;
        bit held = 1'b0;
        word_t hv = '0;
        dcyc = 0;
        busy_hi = 0;
        for (int k = 0; k < N; k++) res[k] = '0;
        while (got < N && dcyc < 40) begin
            if (!bus.out_valid) flag_bad++;
            if (bus.busy) busy_hi++;
            if (bus.in_ready) early++;
            if (held && bus.out_data != hv) unstable++;
            if (offer) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 6'd33;
            end
            bus.out_ready = rdy[dcyc % 16];
            if (bus.out_ready) begin
                res[got] = bus.out_data;
                got++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hv   = bus.out_data;
            end
            @(negedge clk);
            dcyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("drain_transfers", got, N);
        check("drain_valid_bad", flag_bad, 0);
        check("drain_in_ready_early", early, 0);
        check("drain_unstable", unstable, 0);
        check_idle("post_drain");
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int sort_cnt;
        int dcyc;
        int busy_hi;
        word_t res [N];
        send(v.din, v.gap);
        wait_sort(sort_cnt);
        drain(v.rdy, v.offer, res, dcyc, busy_hi);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_word%0d", tag, k), int'(res[k]), int'(v.exp[k]));
        end
        if (v.rdy == 16'hFFFF) begin
            check({tag, "_drain_cycles"}, dcyc, N);
            check({tag, "_busy_cycles"}, sort_cnt + busy_hi, SORT_CYC + N);
        end else begin
            check({tag, "_busy_drain"}, busy_hi, dcyc);
        end
    endtask

    task automatic abort_seq();
        word_t w [N] = '{6'd11, 6'd22, 6'd33, 6'd44};
        int bad = 0;
        send(w, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (!bus.busy || bus.out_valid) bad++;
        end
        check("abort_in_sort", bad, 0);
        rst_n = 1'b0;
        #1;
        check_idle("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("abort_release");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        tbl[0] = '{din: '{6'd5, 6'd12, 6'd3, 6'd63},  exp: '{6'd63, 6'd12, 6'd5, 6'd3},
                   gap: 1'b0, rdy: 16'hFFFF, offer: 1'b0, abort_first: 1'b0};
        tbl[1] = '{din: '{6'd7, 6'd0, 6'd7, 6'd63},   exp: '{6'd63, 6'd7, 6'd7, 6'd0},
                   gap: 1'b1, rdy: 16'hFFFF, offer: 1'b0, abort_first: 1'b0};
        tbl[2] = '{din: '{6'd0, 6'd0, 6'd0, 6'd0},    exp: '{6'd0, 6'd0, 6'd0, 6'd0},
                   gap: 1'b0, rdy: 16'hFFFF, offer: 1'b0, abort_first: 1'b0};
        tbl[3] = '{din: '{6'd1, 6'd2, 6'd3, 6'd4},    exp: '{6'd4, 6'd3, 6'd2, 6'd1},
                   gap: 1'b0, rdy: 16'hFFFF, offer: 1'b0, abort_first: 1'b0};
        tbl[4] = '{din: '{6'd40, 6'd30, 6'd20, 6'd10}, exp: '{6'd40, 6'd30, 6'd20, 6'd10},
                   gap: 1'b0, rdy: 16'hFFE9, offer: 1'b0, abort_first: 1'b0};
        tbl[5] = '{din: '{6'd9, 6'd1, 6'd8, 6'd2},    exp: '{6'd9, 6'd8, 6'd2, 6'd1},
                   gap: 1'b0, rdy: 16'hFFFF, offer: 1'b1, abort_first: 1'b1};
        tbl[6] = '{din: '{6'd33, 6'd34, 6'd35, 6'd36}, exp: '{6'd36, 6'd35, 6'd34, 6'd33},
                   gap: 1'b1, rdy: 16'hFFFF, offer: 1'b0, abort_first: 1'b0};

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].abort_first) abort_seq();
            run_vec(tbl[t], $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 30; r++) begin
            vec_t v;
            for (int k = 0; k < N; k++) v.din[k] = word_t'($urandom_range(0, 63));
            ref_sort(v.din, v.exp);
            v.gap         = 1'($urandom_range(0, 1));
            v.rdy         = (r % 3 == 0) ? 16'hFFFF : (16'($urandom) | 16'h8421);
            v.offer       = 1'($urandom_range(0, 1));
            v.abort_first = 1'b0;
            run_vec(v, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cas_sort_seq.md
Name: cas_sort_seq

Overview:
- Time-multiplexed sorter for stochastic-number (SNG) words.
- One shared compare-and-swap datapath sorts a vector of NUM words, stored in a local register file, using an odd-even transposition schedule.
- Words are loaded serially through a valid/ready input port and drained in descending order through a valid/ready output port.
- Serves as a low-area alternative to a fully parallel sorting network, placed between SNG word producers and downstream consumers.

Parameters:
- WIDTH, 6, bit width of each word, unsigned.
- NUM, 4, words per vector; even, >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data carries a word.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  input word.
- out_valid  output  1  out_data carries a sorted word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  sorted output word; 0 whenever out_valid=0.
- busy  output  1  high in SORT and DRAIN.

Behaviour:
- Reset:
  - state=LOAD; register file, pointers, pass and pair counters cleared to 0.
  - Outputs during reset: in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset asserted mid-operation discards the vector. Block restarts in LOAD.
- States: LOAD, SORT, DRAIN. The handshake outputs are decoded from state only; there is no combinational path from in_valid or out_ready.
- LOAD:
  - in_ready=1.
  - Accept occurs on in_valid&&in_ready. The word is written to mem[wr_ptr] and wr_ptr increments.
  - Accept with wr_ptr=NUM-1: wr_ptr wraps to 0 and the next state is SORT.
  - in_valid low leaves state unchanged; in_data is ignored.
- SORT:
  - in_ready=0, out_valid=0, busy=1.
  - Exactly one comparison per cycle.
  - Pass p runs 0..NUM-1. Even p compares pairs (0,1),(2,3),...; odd p compares pairs (1,2),(3,4),...,(NUM-3,NUM-2).
  - Each cycle compares mem[i] (a) and mem[i+1] (b).
  - Compare rule: compute the WIDTH+1-bit difference a-b and test its MSB (the borrow). Borrow=1 swaps the pair. Borrow=0 leaves it unchanged, including the equal case.
  - Result: descending order, with the maximum at index 0.
  - Total SORT cycles: NUM*(NUM-1)/2. That is 6 for NUM=4 and 1 for NUM=2.
  - After the final comparison the next state is DRAIN.
- DRAIN:
  - out_valid=1, out_data=mem[rd_ptr], busy=1.
  - On out_valid&&out_ready, rd_ptr increments. Transfer of index NUM-1 wraps rd_ptr to 0 and returns to LOAD.
  - While out_ready=0, out_data and out_valid hold stable.
- Latency:
  - Last input accept at edge T. SORT occupies cycles T+1..T+NUM*(NUM-1)/2.
  - out_valid is first high in the cycle following the last SORT cycle: cycle T+7 for NUM=4.
  - With out_ready held high, NUM words drain in NUM consecutive cycles. in_ready rises the cycle after the last transfer.
- Overlap: no overlap between vectors. in_ready=0 throughout SORT and DRAIN, and in_valid is ignored there.
- Width: the register file is NUM x WIDTH. Pointers are clog2(NUM) bits. The pass counter is clog2(NUM)+1 bits.

Test Plan:
- NUM=4. Load 5,12,3,63 with in_valid high every cycle and out_ready=1 -> out 63,12,5,3 on consecutive cycles. First out_valid is 7 cycles after the last accept edge. busy high for 10 cycles.
- Duplicates and boundaries: load 7,0,7,63 -> out 63,7,7,0. Load 0,0,0,0 -> out 0,0,0,0. No X on out_data.
- Orderings: ascending 1,2,3,4 -> 4,3,2,1. Descending 40,30,20,10 -> 40,30,20,10. Check after exactly 6 SORT cycles in both cases.
- Backpressure: during DRAIN toggle out_ready 1,0,0,1,0,1,1 -> each word is transferred exactly once. out_data is stable while out_ready=0, and in_ready=0 until the 4th transfer.
- Reset mid-operation: assert rst_n=0 on the 3rd SORT cycle -> outputs immediately take reset values (in_ready=1, out_valid=0, out_data=0, busy=0). A new vector 9,1,8,2 then yields 9,8,2,1.
- Gapped input and back-to-back vectors: in_valid low on alternating cycles, and a second vector 33,34,35,36 offered during DRAIN -> the second vector is not accepted until LOAD. It then sorts to 36,35,34,33.
